rf_writeback_unit: RTL

- Writeback stage directly upstream of the 32x32 register file; it produces the RF write port signals (reg_write, dst_addr, dst_data) that the RF samples on the falling clock edge.
- Merges two result sources onto the single RF write port:
  - the single-cycle ALU path;
  - a long-latency multiply/divide (MDU) path, buffered in a small FIFO.
- Maintains a pending-write scoreboard that the hazard unit uses to stall dependent instructions.

---
 rtl/rf_writeback_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rf_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_unit
// Brief   : Merges ALU and buffered MDU results onto the RF write port and
//           tracks outstanding MDU writes in a pending scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module rf_writeback_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_dst,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_stall,
    input  logic        i_mdu_valid,
    output logic        o_mdu_ready,
    input  logic [4:0]  i_mdu_dst,
    input  logic [31:0] i_mdu_data,
    input  logic        i_iss_valid,
    input  logic [4:0]  i_iss_dst,
    output logic [31:0] o_pending,
    output logic        o_wb_reg_write,
    output logic [4:0]  o_wb_dst_addr,
    output logic [31:0] o_wb_dst_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] c_DEPTH      = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);

    logic [4:0]    r_fifo_dst  [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve_cnt;
    logic [31:0]   r_pending;
    logic          r_wb_reg_write;
    logic [4:0]    r_wb_dst_addr;
    logic [31:0]   r_wb_dst_data;

    logic          w_empty;
    logic          w_sel_alu;
    logic          w_pop;
    logic          w_push;
    logic [4:0]    w_head_dst;
    logic [31:0]   w_head_data;
    logic [31:0]   w_pend_set;
    logic [31:0]   w_pend_clr;

    assign w_empty     = (r_count == '0);
    assign o_mdu_ready = (r_count != c_DEPTH);
    assign o_alu_stall = (r_starve_cnt == c_STARVE_MAX);
    assign w_sel_alu   = i_alu_valid && !o_alu_stall;
    assign w_pop       = !w_sel_alu && !w_empty;
    assign w_push      = i_mdu_valid && o_mdu_ready;
    assign w_head_dst  = r_fifo_dst[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_dst_addr  = r_wb_dst_addr;
    assign o_wb_dst_data  = r_wb_dst_data;
    assign o_pending      = r_pending;

    // Set has priority over clear for the same register; bit 0 never set.
    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (i_iss_valid && (i_iss_dst != 5'd0))
            w_pend_set[i_iss_dst] = 1'b1;
        if (w_pop && (w_head_dst != 5'd0))
            w_pend_clr[w_head_dst] = 1'b1;
    end

    // Storage carries no reset; validity is governed by count and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dst[r_wr_ptr]  <= i_mdu_dst;
            r_fifo_data[r_wr_ptr] <= i_mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_sel_alu) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pending <= '0;
        else
            r_pending <= ((r_pending & ~w_pend_clr) | w_pend_set) & ~32'd1;
    end

    // With nothing selected the address/data hold so the RF port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_reg_write <= 1'b0;
            r_wb_dst_addr  <= '0;
            r_wb_dst_data  <= '0;
        end else if (w_sel_alu) begin
            r_wb_reg_write <= (i_alu_dst != 5'd0);
            r_wb_dst_addr  <= i_alu_dst;
            r_wb_dst_data  <= i_alu_data;
        end else if (w_pop) begin
            r_wb_reg_write <= (w_head_dst != 5'd0);
            r_wb_dst_addr  <= w_head_dst;
            r_wb_dst_data  <= w_head_data;
        end else begin
            r_wb_reg_write <= 1'b0;
        end
    end

endmodule
`default_nettype wire
